// File: rtl/lsu_if.sv
// Bundle of ex-side op, data-memory bus, writeback and fault signals around the load/store unit.
interface lsu_if #(
    parameter int unsigned XLEN = 32
);
    logic            ex_valid;
    logic            ex_read_en;
    logic            ex_write_en;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_addr;
    logic [XLEN-1:0] ex_write_data;
    logic [4:0]      ex_rd;
    logic            stall;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_wstrb;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            fault;
    logic [1:0]      fault_cause;
    logic [XLEN-1:0] fault_addr;

    modport slave (
        input  ex_valid, ex_read_en, ex_write_en, ex_funct3, ex_addr, ex_write_data, ex_rd,
        input  dmem_ack, dmem_rdata,
        output stall, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output wb_valid, wb_rd, wb_data, fault, fault_cause, fault_addr
    );

    modport master (
        output ex_valid, ex_read_en, ex_write_en, ex_funct3, ex_addr, ex_write_data, ex_rd,
        output dmem_ack, dmem_rdata,
        input  stall, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  wb_valid, wb_rd, wb_data, fault, fault_cause, fault_addr
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op from ex, runs a req/ack bus access with timeout,
// formats load data for writeback and reports misaligned/illegal/timeout faults.
module lsu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic            is_load;
    } op_t;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_t             op_q, op_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] daddr_q, daddr_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            fault_q, fault_d;
    logic [1:0]      cause_q, cause_d;
    logic [XLEN-1:0] faddr_q, faddr_d;

    logic            accept, illegal, misaligned, legal;
    logic [XLEN-1:0] shifted, load_data;

    // Accept qualification; illegal size takes precedence over misalignment.
    always_comb begin
        accept     = (state_q == IDLE) && bus.ex_valid && (bus.ex_read_en || bus.ex_write_en);
        illegal    = (bus.ex_funct3 == 3'b011) || (bus.ex_funct3[2:1] == 2'b11) ||
                     (bus.ex_write_en && bus.ex_funct3[2]);
        misaligned = ((bus.ex_funct3[1:0] == 2'b01) && bus.ex_addr[0]) ||
                     ((bus.ex_funct3[1:0] == 2'b10) && (bus.ex_addr[1:0] != 2'b00));
        legal      = accept && !illegal && !misaligned;
    end

    assign bus.stall = legal || ((state_q == BUSY) && !bus.dmem_ack);

    // Lane select and sign/zero extension of returned load data.
    always_comb begin
        shifted = bus.dmem_rdata >> {op_q.addr[1:0], 3'b000};
        case (op_q.funct3)
            3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        req_d      = req_q;
        we_d       = we_q;
        daddr_d    = daddr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        fault_d    = 1'b0;
        cause_d    = cause_q;
        faddr_d    = faddr_q;
        case (state_q)
            IDLE: begin
                if (accept && illegal) begin
                    fault_d = 1'b1;
                    cause_d = 2'b10;
                    faddr_d = bus.ex_addr;
                end else if (accept && misaligned) begin
                    fault_d = 1'b1;
                    cause_d = 2'b01;
                    faddr_d = bus.ex_addr;
                end else if (accept) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    op_d    = '{addr: bus.ex_addr, funct3: bus.ex_funct3, rd: bus.ex_rd,
                                is_load: !bus.ex_write_en};
                    req_d   = 1'b1;
                    we_d    = bus.ex_write_en;
                    daddr_d = {bus.ex_addr[XLEN-1:2], 2'b00};
                    wstrb_d = 4'b0000;
                    wdata_d = '0;
                    if (bus.ex_write_en) begin
                        case (bus.ex_funct3[1:0])
                            2'b00: begin
                                wstrb_d = 4'b0001 << bus.ex_addr[1:0];
                                wdata_d = {(XLEN/8){bus.ex_write_data[7:0]}};
                            end
                            2'b01: begin
                                wstrb_d = 4'b0011 << bus.ex_addr[1:0];
                                wdata_d = {(XLEN/16){bus.ex_write_data[15:0]}};
                            end
                            default: begin
                                wstrb_d = 4'b1111;
                                wdata_d = bus.ex_write_data;
                            end
                        endcase
                    end
                end
            end
            BUSY: begin
                if (bus.dmem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    if (op_q.is_load) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = op_q.rd;
                        wb_data_d  = load_data;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    cause_d = 2'b11;
                    faddr_d = op_q.addr;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            daddr_q    <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            fault_q    <= 1'b0;
            cause_q    <= '0;
            faddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            req_q      <= req_d;
            we_q       <= we_d;
            daddr_q    <= daddr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            fault_q    <= fault_d;
            cause_q    <= cause_d;
            faddr_q    <= faddr_d;
        end
    end

    assign bus.dmem_req    = req_q;
    assign bus.dmem_we     = we_q;
    assign bus.dmem_addr   = daddr_q;
    assign bus.dmem_wstrb  = wstrb_q;
    assign bus.dmem_wdata  = wdata_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.fault       = fault_q;
    assign bus.fault_cause = cause_q;
    assign bus.fault_addr  = faddr_q;
endmodule
